// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, word size and halt encoding.
package fetch_sequencer_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next_mux.sv
// Next-PC selection: stall holds, jump beats branch, otherwise sequential fetch.
module pc_next_mux
  import fetch_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] next_pc,
  output logic        redirect
);

  always_comb begin
    next_pc  = pc + 32'(WORD_BYTES);
    redirect = 1'b0;
    if (stall) begin
      next_pc = pc;
    end else if (jump) begin
      next_pc  = align_word(jump_target);
      redirect = 1'b1;
    end else if (branch_taken) begin
      next_pc  = align_word(branch_target);
      redirect = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Sequences InstructionMemory: load phase, PC ownership during run, halt detection and restart.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned LOAD_CYCLES = 2,
  parameter int unsigned MEM_BYTES   = 80,
  parameter logic [31:0] HALT_WORD   = HALT_WORD_DEFAULT,
  parameter logic [31:0] RESET_PC    = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] instruction,
  output logic [31:0] imem_address,
  output logic        imem_startin,
  output logic [31:0] pc,
  output logic        instr_valid,
  output logic        halted,
  output logic [31:0] retired_count
);

  localparam int unsigned CNT_W   = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - WORD_BYTES);
  localparam logic [31:0] MEM_END = 32'(MEM_BYTES);

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
  logic [31:0]       retired_q, retired_d;
  logic              startin_q, startin_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;

  logic [31:0]       mux_next_pc;
  logic              mux_redirect;
  logic [31:0]       retired_inc;

  pc_next_mux u_pc_next_mux (
    .pc            (pc_q),
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .next_pc       (mux_next_pc),
    .redirect      (mux_redirect)
  );

  assign retired_inc = (retired_q == 32'hFFFF_FFFF) ? retired_q : retired_q + 32'd1;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    load_cnt_d = load_cnt_q;
    retired_d  = retired_q;
    unique case (state_q)
      ST_LOAD: begin
        if (load_cnt_q == CNT_LAST) begin
          state_d    = ST_RUN;
          load_cnt_d = '0;
        end else begin
          load_cnt_d = load_cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        // A stalled cycle neither retires nor halts; the held word is re-examined next cycle.
        if (!stall) begin
          if (instruction == HALT_WORD) begin
            state_d = ST_HALT;
          end else begin
            retired_d = retired_inc;
            if (mux_redirect) begin
              pc_d = mux_next_pc;
              if (mux_next_pc >= MEM_END) state_d = ST_HALT;
            end else if (pc_q == LAST_PC) begin
              state_d = ST_HALT;
            end else begin
              pc_d = mux_next_pc;
            end
          end
        end
      end
      ST_HALT: begin
        if (restart) begin
          state_d    = ST_LOAD;
          pc_d       = RESET_PC;
          load_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_LOAD;
        pc_d       = RESET_PC;
        load_cnt_d = '0;
      end
    endcase
    startin_d = (state_d == ST_LOAD);
    valid_d   = (state_d == ST_RUN);
    halted_d  = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      pc_q       <= RESET_PC;
      load_cnt_q <= '0;
      retired_q  <= '0;
      startin_q  <= 1'b1;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      load_cnt_q <= load_cnt_d;
      retired_q  <= retired_d;
      startin_q  <= startin_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_address  = pc_q;
  assign pc            = pc_q;
  assign imem_startin  = startin_q;
  assign instr_valid   = valid_q;
  assign halted        = halted_q;
  assign retired_count = retired_q;

endmodule
